// File: rtl/elev_pkg.sv
// Shared types and helpers for the elevator controller.
package elev_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2,
        HALT = 2'd3
    } elev_state_t;

    // Width of a floor index; never narrower than one bit.
    function automatic int unsigned floor_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter shared by the travel and door phases.
module elev_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q, count_d;
    logic         done_q;

    // Load wins over counting; the counter parks at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // done mirrors count == 0 without a combinational path to the consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            done_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            done_q  <= (count_d == '0);
        end
    end

    assign done = done_q;

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller: call latching, up-first sweep policy,
// door dwell and optional emergency halt (enabled by defining ELEV_ESTOP_EN).
module elevator_ctrl
    import elev_pkg::*;
#(
    parameter int unsigned NUM_FLOORS      = 4,
    parameter int unsigned TICKS_PER_FLOOR = 200_000_000,
    parameter int unsigned DOOR_TICKS      = 300_000_000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_FLOORS-1:0]            req,
    input  logic                             estop,
    output logic [floor_w(NUM_FLOORS)-1:0]   floor,
    output logic                             drc,
    output logic                             starter,
    output logic                             stop,
    output logic [NUM_FLOORS-1:0]            pending
);

    localparam int unsigned FW        = floor_w(NUM_FLOORS);
    localparam int unsigned MAX_TICKS = (TICKS_PER_FLOOR > DOOR_TICKS) ? TICKS_PER_FLOOR : DOOR_TICKS;
    localparam int unsigned TW        = $clog2(MAX_TICKS + 1);
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TICKS_PER_FLOOR - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_TICKS - 1);

    elev_state_t           state_q, state_d;
    elev_state_t           halt_ret_q, halt_ret_d;
    logic [FW-1:0]         floor_q, floor_d;
    logic                  drc_q, drc_d;
    logic                  starter_q, starter_d;
    logic                  stop_q, stop_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;

    logic                  tmr_load, tmr_en, tmr_done;
    logic [TW-1:0]         tmr_load_val;
    logic                  estop_c;
    logic                  above_c, below_c, ahead_c, behind_c;
    logic [NUM_FLOORS-1:0] here_c;
    logic [FW-1:0]         next_floor_c;

`ifdef ELEV_ESTOP_EN
    assign estop_c = estop;
`else
    logic unused_estop;
    assign unused_estop = estop;
    assign estop_c      = 1'b0;
`endif

    elev_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .enable   (tmr_en),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    // Call geometry relative to the car: above/below, ahead/behind, next stop.
    always_comb begin
        above_c = 1'b0;
        below_c = 1'b0;
        here_c  = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (i > 32'(floor_q)) above_c = above_c | pending_q[i];
            if (i < 32'(floor_q)) below_c = below_c | pending_q[i];
        end
        here_c[floor_q] = 1'b1;
        ahead_c      = drc_q ? above_c : below_c;
        behind_c     = drc_q ? below_c : above_c;
        next_floor_c = drc_q ? (floor_q + FW'(1)) : (floor_q - FW'(1));
    end

    // Next-state, call latching and timer control.
    always_comb begin
        state_d      = state_q;
        halt_ret_d   = halt_ret_q;
        floor_d      = floor_q;
        drc_d        = drc_q;
        pending_d    = pending_q | req;
        tmr_load     = 1'b0;
        tmr_load_val = TRAVEL_LOAD;
        tmr_en       = (state_q == MOVE) || (state_q == DOOR);

        // A call at the floor the car is parked at is served, not latched.
        if ((state_q == IDLE) || (state_q == DOOR)) begin
            pending_d = pending_q | (req & ~here_c);
        end

        if (estop_c && (state_q != HALT)) begin
            state_d    = HALT;
            halt_ret_d = state_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req[floor_q] || pending_q[floor_q]) begin
                        state_d      = DOOR;
                        pending_d    = pending_d & ~here_c;
                        tmr_load     = 1'b1;
                        tmr_load_val = DOOR_LOAD;
                    end else if (above_c) begin
                        state_d  = MOVE;
                        drc_d    = 1'b1;
                        tmr_load = 1'b1;
                    end else if (below_c) begin
                        state_d  = MOVE;
                        drc_d    = 1'b0;
                        tmr_load = 1'b1;
                    end
                end
                MOVE: begin
                    if (tmr_done) begin
                        floor_d  = next_floor_c;
                        tmr_load = 1'b1;
                        if (pending_q[next_floor_c] || req[next_floor_c]) begin
                            state_d                 = DOOR;
                            pending_d[next_floor_c] = 1'b0;
                            tmr_load_val            = DOOR_LOAD;
                        end
                    end
                end
                DOOR: begin
                    if (req[floor_q]) begin
                        tmr_load     = 1'b1;
                        tmr_load_val = DOOR_LOAD;
                    end else if (tmr_done) begin
                        if (ahead_c) begin
                            state_d  = MOVE;
                            tmr_load = 1'b1;
                        end else if (behind_c) begin
                            state_d  = MOVE;
                            drc_d    = ~drc_q;
                            tmr_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                HALT: begin
                    if (!estop_c) state_d = halt_ret_q;
                end
                default: state_d = IDLE;
            endcase
        end

        starter_d = (state_d == MOVE);
        stop_d    = (state_d == DOOR) || (state_d == HALT);
    end

    // State and registered outputs; reset overrides calls and estop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            halt_ret_q <= IDLE;
            floor_q    <= '0;
            drc_q      <= 1'b1;
            starter_q  <= 1'b0;
            stop_q     <= 1'b0;
            pending_q  <= '0;
        end else begin
            state_q    <= state_d;
            halt_ret_q <= halt_ret_d;
            floor_q    <= floor_d;
            drc_q      <= drc_d;
            starter_q  <= starter_d;
            stop_q     <= stop_d;
            pending_q  <= pending_d;
        end
    end

    assign floor   = floor_q;
    assign drc     = drc_q;
    assign starter = starter_q;
    assign stop    = stop_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed scoreboard bench for elevator_ctrl (4 floors, 10-cycle floors, 5-cycle door).
module tb_elevator_ctrl;

    localparam int unsigned NF  = 4;
    localparam int unsigned TPF = 10;
    localparam int unsigned DT  = 5;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       estop;
    logic [1:0] floor;
    logic       drc;
    logic       starter;
    logic       stop;
    logic [3:0] pending;

    typedef struct {
        int         cyc;
        string      tag;
        logic [8:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    elevator_ctrl #(
        .NUM_FLOORS      (NF),
        .TICKS_PER_FLOOR (TPF),
        .DOOR_TICKS      (DT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .estop   (estop),
        .floor   (floor),
        .drc     (drc),
        .starter (starter),
        .stop    (stop),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected snapshot after posedge number c: {floor, drc, starter, stop, pending}.
    task automatic expect_at(input int c, input string tag, input int f, input bit d,
                             input bit s, input bit p, input logic [3:0] pd);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.val = {2'(f), d, s, p, pd};
        sb.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Scoreboard consumer and floor-range check, sampled mid-cycle.
    always @(negedge clk) begin
        logic [8:0] obs;
        exp_t       e;
        obs = {floor, drc, starter, stop, pending};
        vectors++;
        assert (32'(floor) < NF) else begin
            miscompares++;
            $error("FAIL floor_range @cycle %0d: observed %0d required < %0d", cyc, floor, NF);
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            vectors++;
            assert (e.cyc == cyc && obs === e.val) else begin
                miscompares++;
                $error("FAIL %s @cycle %0d: observed %b expected %b (floor,drc,starter,stop,pending)",
                       e.tag, cyc, obs, e.val);
            end
        end
    end

    initial begin
        int b;
        reset = 1'b1;
        req   = 4'b0000;
        estop = 1'b0;

        // Reset state
        @(negedge clk);
        expect_at(cyc + 1, "reset", 0, 1, 0, 0, 4'b0000);
        @(negedge clk);

        // Call to top floor from ground
        b = cyc;
        reset = 1'b0;
        req   = 4'b1000;
        expect_at(b + 1,  "a_latch",    0, 1, 0, 0, 4'b1000);
        expect_at(b + 2,  "a_start",    0, 1, 1, 0, 4'b1000);
        expect_at(b + 11, "a_pre_f1",   0, 1, 1, 0, 4'b1000);
        expect_at(b + 12, "a_f1",       1, 1, 1, 0, 4'b1000);
        expect_at(b + 31, "a_f2",       2, 1, 1, 0, 4'b1000);
        expect_at(b + 32, "a_arrive",   3, 1, 0, 1, 4'b0000);
        expect_at(b + 36, "a_door_end", 3, 1, 0, 1, 4'b0000);
        expect_at(b + 37, "a_idle",     3, 1, 0, 0, 4'b0000);
        wait_until(b + 1);
        req = 4'b0000;
        wait_until(b + 38);

        // Up to 1, then calls at 2 and 0: serve 2 first, reverse to 0
        b = cyc;
        reset = 1'b1;
        expect_at(b + 1,  "b_reset",     0, 1, 0, 0, 4'b0000);
        expect_at(b + 2,  "b_latch",     0, 1, 0, 0, 4'b0010);
        expect_at(b + 3,  "b_start",     0, 1, 1, 0, 4'b0010);
        expect_at(b + 13, "b_door1",     1, 1, 0, 1, 4'b0000);
        expect_at(b + 15, "b_calls",     1, 1, 0, 1, 4'b0101);
        expect_at(b + 18, "b_go_up",     1, 1, 1, 0, 4'b0101);
        expect_at(b + 28, "b_door2",     2, 1, 0, 1, 4'b0001);
        expect_at(b + 33, "b_reverse",   2, 0, 1, 0, 4'b0001);
        expect_at(b + 43, "b_pass1",     1, 0, 1, 0, 4'b0001);
        expect_at(b + 53, "b_door0",     0, 0, 0, 1, 4'b0000);
        expect_at(b + 58, "b_idle",      0, 0, 0, 0, 4'b0000);
        wait_until(b + 1);
        reset = 1'b0;
        req   = 4'b0010;
        wait_until(b + 2);
        req = 4'b0000;
        wait_until(b + 14);
        req = 4'b0101;
        wait_until(b + 15);
        req = 4'b0000;
        wait_until(b + 58);

        // Call at current floor while idle, then door extension
        b = cyc;
        req = 4'b0001;
        expect_at(b + 1, "c_door",     0, 0, 0, 1, 4'b0000);
        expect_at(b + 2, "c_nolatch",  0, 0, 0, 1, 4'b0000);
        expect_at(b + 4, "c_reload",   0, 0, 0, 1, 4'b0000);
        expect_at(b + 6, "c_extended", 0, 0, 0, 1, 4'b0000);
        expect_at(b + 8, "c_ext_last", 0, 0, 0, 1, 4'b0000);
        expect_at(b + 9, "c_closed",   0, 0, 0, 0, 4'b0000);
        wait_until(b + 1);
        req = 4'b0000;
        wait_until(b + 3);
        req = 4'b0001;
        wait_until(b + 4);
        req = 4'b0000;
        wait_until(b + 9);

        // Reset in the middle of travel between 1 and 2
        b = cyc;
        req = 4'b0100;
        expect_at(b + 1,  "d_latch",  0, 0, 0, 0, 4'b0100);
        expect_at(b + 2,  "d_start",  0, 1, 1, 0, 4'b0100);
        expect_at(b + 12, "d_f1",     1, 1, 1, 0, 4'b0100);
        expect_at(b + 16, "d_mid",    1, 1, 1, 0, 4'b0100);
        expect_at(b + 17, "d_reset",  0, 1, 0, 0, 4'b0000);
        expect_at(b + 18, "d_after",  0, 1, 0, 0, 4'b0000);
        wait_until(b + 1);
        req = 4'b0000;
        wait_until(b + 16);
        reset = 1'b1;
        wait_until(b + 17);
        reset = 1'b0;
        wait_until(b + 18);

        // Seven-cycle estop pulse mid-travel
        b = cyc;
        req = 4'b0010;
        expect_at(b + 1, "e_latch", 0, 1, 0, 0, 4'b0010);
        expect_at(b + 2, "e_start", 0, 1, 1, 0, 4'b0010);
`ifdef ELEV_ESTOP_EN
        expect_at(b + 6,  "e_halt",      0, 1, 0, 1, 4'b0010);
        expect_at(b + 12, "e_halt_end",  0, 1, 0, 1, 4'b0010);
        expect_at(b + 13, "e_resume",    0, 1, 1, 0, 4'b0010);
        expect_at(b + 18, "e_pre_arr",   0, 1, 1, 0, 4'b0010);
        expect_at(b + 19, "e_arrive",    1, 1, 0, 1, 4'b0000);
`else
        expect_at(b + 6,  "e_ignored",   0, 1, 1, 0, 4'b0010);
        expect_at(b + 12, "e_arrive",    1, 1, 0, 1, 4'b0000);
        expect_at(b + 13, "e_door",      1, 1, 0, 1, 4'b0000);
        expect_at(b + 18, "e_idle",      1, 1, 0, 0, 4'b0000);
        expect_at(b + 19, "e_idle2",     1, 1, 0, 0, 4'b0000);
`endif
        wait_until(b + 1);
        req = 4'b0000;
        wait_until(b + 5);
        estop = 1'b1;
        wait_until(b + 12);
        estop = 1'b0;
        wait_until(b + 27);

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_drain: observed %0d unchecked entries, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
